// File: rtl/snoopy_bus_pkg.sv
// Shared types and index-slicing helpers for the SystemBus controller and its caches.
package snoopy_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_stat_t;

    localparam int NPORTS    = 2;
    localparam int BUS_WIDTH = 128;
    localparam int BUS_DEPTH = 4096;

    // Word index = addr[offset_bits(width) +: index_bits(depth)]
    function automatic int offset_bits(input int width);
        return $clog2(width / 8);
    endfunction

    function automatic int index_bits(input int depth);
        return $clog2(depth);
    endfunction

    localparam int BUS_OFFSET_BITS = offset_bits(BUS_WIDTH);
    localparam int BUS_INDEX_BITS  = index_bits(BUS_DEPTH);

endpackage

// File: rtl/system_bus_if.sv
// SystemBus: single-outstanding read/write channel plus an invalidation side channel.
interface SystemBus #(
    parameter int WIDTH      = 128,
    parameter int ADDR_WIDTH = 32
);
    logic                   rw_valid;
    logic                   rw_ready;
    logic [ADDR_WIDTH-1:0]  rw_addr;
    logic                   rw_we;
    logic [WIDTH/8-1:0]     w_mask;
    logic [WIDTH-1:0]       w_data;
    logic                   w_ce;
    logic [WIDTH-1:0]       r_data;
    logic                   inv_valid;
    logic [ADDR_WIDTH-1:0]  inv_addr;
    logic                   inv_ready;

    modport provider (
        input  rw_valid, rw_addr, rw_we, w_mask, w_data, w_ce, inv_ready,
        output rw_ready, r_data, inv_valid, inv_addr
    );

    modport requester (
        output rw_valid, rw_addr, rw_we, w_mask, w_data, w_ce, inv_ready,
        input  rw_ready, r_data, inv_valid, inv_addr
    );
endinterface

// File: rtl/snoopy_bus_ctrl_bram.sv
// Simple dual-port block RAM: port A byte-masked write, port B registered read.
module bram #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     a_en,
    input  logic [WIDTH/8-1:0]       a_mask,
    input  logic [$clog2(DEPTH)-1:0] a_addr,
    input  logic [WIDTH-1:0]         a_data,
    input  logic                     b_en,
    input  logic [$clog2(DEPTH)-1:0] b_addr,
    output logic [WIDTH-1:0]         b_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_en) begin
            for (int i = 0; i < WIDTH / 8; i++) begin
                if (a_mask[i]) begin
                    mem[a_addr][i*8 +: 8] <= a_data[i*8 +: 8];
                end
            end
        end
        if (b_en) begin
            b_data <= mem[b_addr];
        end
    end
endmodule

// File: rtl/snoopy_bus_ctrl.sv
// Two-port SystemBus responder over a block RAM; cacheable writes broadcast
// invalidations to both ports when SNOOPY_BUS_INV_EN is defined.
module snoopy_bus_ctrl
    import snoopy_bus_pkg::*;
#(
    parameter int WIDTH      = BUS_WIDTH,
    parameter int MASKW      = WIDTH / 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = BUS_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    SystemBus.provider bus0,
    SystemBus.provider bus1
);
    localparam int OFFW = offset_bits(WIDTH);
    localparam int IDXW = index_bits(DEPTH);

    bus_stat_t state_q, state_d;
    logic      gnt_q, gnt_d;
    logic      rd_q, rd_d;

    logic [NPORTS-1:0] req_valid;
    logic [NPORTS-1:0] req_we;
    logic [NPORTS-1:0] elig;
    logic [NPORTS-1:0] ready_vec;
    logic [NPORTS-1:0] inv_valid;
    logic [IDXW-1:0]   req_idx   [NPORTS];
    logic [MASKW-1:0]  req_mask  [NPORTS];
    logic [WIDTH-1:0]  req_data  [NPORTS];
    logic [WIDTH-1:0]  rdata_port[NPORTS];

    logic              mem_wr;
    logic              mem_rd;
    logic [IDXW-1:0]   mem_idx;
    logic [MASKW-1:0]  mem_mask;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;

    assign req_valid[0] = bus0.rw_valid;
    assign req_valid[1] = bus1.rw_valid;
    assign req_we[0]    = bus0.rw_we;
    assign req_we[1]    = bus1.rw_we;
    assign req_idx[0]   = bus0.rw_addr[OFFW +: IDXW];
    assign req_idx[1]   = bus1.rw_addr[OFFW +: IDXW];
    assign req_mask[0]  = bus0.w_mask;
    assign req_mask[1]  = bus1.w_mask;
    assign req_data[0]  = bus0.w_data;
    assign req_data[1]  = bus1.w_data;

`ifdef SNOOPY_BUS_INV_EN
    logic [NPORTS-1:0]     req_ce;
    logic [NPORTS-1:0]     inv_ready;
    logic [ADDR_WIDTH-1:0] req_addr [NPORTS];
    logic [NPORTS-1:0]     inv_pend_q, inv_pend_d;
    logic [ADDR_WIDTH-1:0] inv_addr_q, inv_addr_d;

    assign req_ce[0]    = bus0.w_ce;
    assign req_ce[1]    = bus1.w_ce;
    assign inv_ready[0] = bus0.inv_ready;
    assign inv_ready[1] = bus1.inv_ready;
    assign req_addr[0]  = bus0.rw_addr;
    assign req_addr[1]  = bus1.rw_addr;

    // A new broadcast overrides any acknowledge sampled in the same cycle.
    always_comb begin
        inv_pend_d = inv_pend_q & ~inv_ready;
        inv_addr_d = inv_addr_q;
        if (state_q == ACCESS && req_we[gnt_q] && req_ce[gnt_q]) begin
            inv_pend_d = '1;
            inv_addr_d = req_addr[gnt_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inv_pend_q <= '0;
            inv_addr_q <= '0;
        end else begin
            inv_pend_q <= inv_pend_d;
            inv_addr_q <= inv_addr_d;
        end
    end

    assign inv_valid     = inv_pend_q;
    assign bus0.inv_addr = inv_addr_q;
    assign bus1.inv_addr = inv_addr_q;
`else
    assign inv_valid     = '0;
    assign bus0.inv_addr = {ADDR_WIDTH{1'b0}};
    assign bus1.inv_addr = {ADDR_WIDTH{1'b0}};
`endif

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        assign ready_vec[gi]  = (state_q == RESP) && (int'(gnt_q) == gi);
        assign rdata_port[gi] = (ready_vec[gi] && rd_q) ? mem_rdata : '0;
`ifdef SNOOPY_BUS_INV_EN
        // Cacheable writes wait until every cache has taken the last invalidation.
        assign elig[gi] = req_valid[gi] && !(req_we[gi] && req_ce[gi] && (|inv_pend_q));
`else
        assign elig[gi] = req_valid[gi];
`endif
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = ACCESS;
                    gnt_d   = (&elig) ? ~gnt_q : elig[1];
                end
            end
            ACCESS: begin
                state_d = RESP;
                rd_d    = !req_we[gnt_q];
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b1;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rd_q    <= rd_d;
        end
    end

    // Request fields are taken live from the granted port during ACCESS.
    always_comb begin
        mem_wr    = (state_q == ACCESS) && req_we[gnt_q];
        mem_rd    = (state_q == ACCESS) && !req_we[gnt_q];
        mem_idx   = req_idx[gnt_q];
        mem_mask  = req_mask[gnt_q];
        mem_wdata = req_data[gnt_q];
    end

    bram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .a_en   (mem_wr),
        .a_mask (mem_mask),
        .a_addr (mem_idx),
        .a_data (mem_wdata),
        .b_en   (mem_rd),
        .b_addr (mem_idx),
        .b_data (mem_rdata)
    );

    assign bus0.rw_ready  = ready_vec[0];
    assign bus1.rw_ready  = ready_vec[1];
    assign bus0.r_data    = rdata_port[0];
    assign bus1.r_data    = rdata_port[1];
    assign bus0.inv_valid = inv_valid[0];
    assign bus1.inv_valid = inv_valid[1];

endmodule

// File: tb/tb_snoopy_bus_ctrl.sv
// Randomized and directed bench for snoopy_bus_ctrl against a transaction-level memory/arbiter model.
module tb_snoopy_bus_ctrl;
`ifdef SNOOPY_BUS_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    SystemBus #(.WIDTH(128), .ADDR_WIDTH(32)) bus0_if ();
    SystemBus #(.WIDTH(128), .ADDR_WIDTH(32)) bus1_if ();

    snoopy_bus_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .bus0 (bus0_if),
        .bus1 (bus1_if)
    );

    logic [1:0]   rdy;
    logic [1:0]   ivld;
    logic [127:0] rdat [2];
    logic [31:0]  iaddr [2];
    assign rdy      = {bus1_if.rw_ready, bus0_if.rw_ready};
    assign ivld     = {bus1_if.inv_valid, bus0_if.inv_valid};
    assign rdat[0]  = bus0_if.r_data;
    assign rdat[1]  = bus1_if.r_data;
    assign iaddr[0] = bus0_if.inv_addr;
    assign iaddr[1] = bus1_if.inv_addr;

    int checks = 0;
    int errors = 0;

    // Transaction fields per port, and the reference model state
    bit           t_we   [2];
    bit           t_ce   [2];
    logic [31:0]  t_addr [2];
    logic [15:0]  t_mask [2];
    logic [127:0] t_data [2];
    logic [127:0] mem_m [int];
    bit           last_m = 1'b1;
    logic [31:0]  inv_addr_m = '0;
    int           pool [8];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input bit v);
        if (p == 0) begin
            bus0_if.rw_valid = v;
            bus0_if.rw_we    = t_we[0];
            bus0_if.w_ce     = t_ce[0];
            bus0_if.rw_addr  = t_addr[0];
            bus0_if.w_mask   = t_mask[0];
            bus0_if.w_data   = t_data[0];
        end else begin
            bus1_if.rw_valid = v;
            bus1_if.rw_we    = t_we[1];
            bus1_if.w_ce     = t_ce[1];
            bus1_if.rw_addr  = t_addr[1];
            bus1_if.w_mask   = t_mask[1];
            bus1_if.w_data   = t_data[1];
        end
    endtask

    task automatic set_inv_ready(input logic [1:0] r);
        bus0_if.inv_ready = r[0];
        bus1_if.inv_ready = r[1];
    endtask

    // Apply port p's request to the model memory; returns the word seen after it.
    task automatic model_access(input int p, output logic [127:0] word);
        int idx;
        idx  = int'((t_addr[p] >> 4) % 4096);
        word = mem_m.exists(idx) ? mem_m[idx] : 'x;
        if (t_we[p]) begin
            for (int b = 0; b < 16; b++)
                if (t_mask[p][b]) word[b*8 +: 8] = t_data[p][b*8 +: 8];
            mem_m[idx] = word;
        end
    endtask

    task automatic run_round(input logic [1:0] req);
        int           exp_k [2];
        logic [127:0] exp_d [2];
        bit           drop  [2];
        bit           exp_iv;
        int           first;
        int           second;
        exp_k = '{-1, -1};
        drop  = '{1'b0, 1'b0};
        if (req == 2'b11) begin
            first  = last_m ? 0 : 1;
            second = 1 - first;
            exp_k[first]  = 2;
            exp_k[second] = 5;
            model_access(first, exp_d[first]);
            model_access(second, exp_d[second]);
            last_m = bit'(second);
        end else begin
            first = req[1] ? 1 : 0;
            exp_k[first] = 2;
            model_access(first, exp_d[first]);
            last_m = bit'(first);
        end
        for (int p = 0; p < 2; p++)
            if (req[p]) set_port(p, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            step();
            for (int p = 0; p < 2; p++)
                if (drop[p]) begin
                    set_port(p, 1'b0);
                    drop[p] = 1'b0;
                end
            exp_iv = 1'b0;
            for (int p = 0; p < 2; p++)
                if (exp_k[p] == k && t_we[p] && t_ce[p] && INV_EN) begin
                    exp_iv     = 1'b1;
                    inv_addr_m = t_addr[p];
                end
            for (int p = 0; p < 2; p++) begin
                check($sformatf("rdy%0d_k%0d", p, k), rdy[p], exp_k[p] == k);
                if (rdy[p]) drop[p] = 1'b1;
                if (exp_k[p] == k && !t_we[p])
                    check($sformatf("rdata%0d_k%0d", p, k), rdat[p], exp_d[p]);
                else if (exp_k[p] != k)
                    check($sformatf("rzero%0d_k%0d", p, k), rdat[p], 0);
                check($sformatf("ivld%0d_k%0d", p, k), ivld[p], exp_iv);
                check($sformatf("iaddr%0d_k%0d", p, k), iaddr[p], inv_addr_m);
            end
        end
        set_port(0, 1'b0);
        set_port(1, 1'b0);
        $display("round req=%b first=%0d we=%b%b ce=%b%b addr0=%h addr1=%h",
                 req, first, t_we[1], t_we[0], t_ce[1], t_ce[0], t_addr[0], t_addr[1]);
    endtask

    task automatic set_txn(input int p, input bit we, input bit ce, input logic [31:0] addr,
                           input logic [15:0] mask, input logic [127:0] data);
        t_we[p] = we; t_ce[p] = ce; t_addr[p] = addr; t_mask[p] = mask; t_data[p] = data;
    endtask

    initial begin
        logic [127:0] scratch;
        int e_cyc;
        int r_cyc;
        for (int p = 0; p < 2; p++) set_txn(p, 1'b0, 1'b0, '0, '0, '0);
        set_port(0, 1'b0);
        set_port(1, 1'b0);
        set_inv_ready(2'b11);
        #2 rst = 1'b0;
        step();
        step();
        for (int p = 0; p < 2; p++) begin
            check($sformatf("rst_rdy%0d", p), rdy[p], 0);
            check($sformatf("rst_rdata%0d", p), rdat[p], 0);
            check($sformatf("rst_ivld%0d", p), ivld[p], 0);
            check($sformatf("rst_iaddr%0d", p), iaddr[p], 0);
        end
        rst = 1'b1;
        step();

        // First tie after reset goes to port 0
        set_txn(0, 1'b1, 1'b0, 32'h40, 16'hFFFF, {16{8'hA5}});
        set_txn(1, 1'b1, 1'b0, 32'h80, 16'hFFFF, 128'h0123456789ABCDEF_FEDCBA9876543210);
        run_round(2'b11);
        set_txn(0, 1'b0, 1'b0, 32'h40, 16'h0, '0);
        run_round(2'b01);
        // Port 0 was last granted, so this tie goes to port 1's masked write
        set_txn(0, 1'b0, 1'b0, 32'h80, 16'h0, '0);
        set_txn(1, 1'b1, 1'b0, 32'h80, 16'h000F, 128'hDEADBEEF_CAFEF00D_0BADC0DE_11223344);
        run_round(2'b11);
        set_txn(1, 1'b0, 1'b0, 32'h80, 16'h0, '0);
        run_round(2'b10);
        set_txn(0, 1'b1, 1'b0, 32'h2000, 16'hFFFF, 128'h5555_0000_AAAA_1111_2222_3333_4444_6666);
        run_round(2'b01);
        step();

        // Invalidation held off by both caches, port 1 refill still served
        set_inv_ready(2'b00);
        set_txn(0, 1'b1, 1'b1, 32'h1000, 16'hFFFF, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321);
        model_access(0, scratch);
        last_m = 1'b0;
        set_port(0, 1'b1);
        step();
        check("inv_w1_k1", rdy[0], 0);
        step();
        check("inv_w1_k2", rdy[0], 1);
        for (int p = 0; p < 2; p++) begin
            check($sformatf("inv_set_vld%0d", p), ivld[p], INV_EN);
            check($sformatf("inv_set_addr%0d", p), iaddr[p], INV_EN ? 32'h1000 : 32'h0);
        end
        step();
        set_port(0, 1'b0);
        set_txn(1, 1'b0, 1'b0, 32'h1000, 16'h0, '0);
        set_port(1, 1'b1);
        set_inv_ready(2'b01);
        check("inv_hold_vld1", ivld[1], INV_EN);
        step();
        set_inv_ready(2'b00);
        check("inv_ack_vld0", ivld[0], 0);
        check("inv_ack_vld1", ivld[1], INV_EN);
        step();
        check("inv_rd_rdy1", rdy[1], 1);
        check("inv_rd_data1", rdat[1], scratch);
        last_m = 1'b1;
        step();
        set_port(1, 1'b0);
        check("inv_still_vld1", ivld[1], INV_EN);
        // Second cacheable write waits for port 1 to acknowledge
        set_txn(0, 1'b1, 1'b1, 32'h1010, 16'hFFFF, 128'hFEED_FACE_0000_1111_2222_3333_4444_5555);
        model_access(0, scratch);
        last_m = 1'b0;
        set_port(0, 1'b1);
        r_cyc = 11;
        e_cyc = INV_EN ? r_cyc + 3 : 8;
        for (int k = 7; k <= 16; k++) begin
            step();
            if (k == e_cyc + 1) set_port(0, 1'b0);
            if (k == r_cyc) set_inv_ready(2'b10);
            if (k == r_cyc + 1) set_inv_ready(2'b00);
            check($sformatf("stall_rdy0_k%0d", k), rdy[0], k == e_cyc);
            check($sformatf("stall_vld1_k%0d", k), ivld[1], INV_EN && (k <= r_cyc || k >= e_cyc));
            check($sformatf("stall_vld0_k%0d", k), ivld[0], INV_EN && k >= e_cyc);
            check($sformatf("stall_addr_k%0d", k), iaddr[0],
                  INV_EN ? ((k >= e_cyc) ? 32'h1010 : 32'h1000) : 32'h0);
        end
        inv_addr_m = INV_EN ? 32'h1010 : 32'h0;
        set_inv_ready(2'b11);
        step();
        check("inv_clear_vld0", ivld[0], 0);
        check("inv_clear_vld1", ivld[1], 0);
        step();

        // Reset during ACCESS aborts the request
        set_txn(0, 1'b1, 1'b1, 32'h3000, 16'hFFFF, {4{32'h0F0F_F0F0}});
        set_port(0, 1'b1);
        step();
        rst = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) begin
            check($sformatf("arst_rdy%0d", p), rdy[p], 0);
            check($sformatf("arst_vld%0d", p), ivld[p], 0);
            check($sformatf("arst_addr%0d", p), iaddr[p], 0);
        end
        step();
        check("arst_rdy0_a", rdy[0], 0);
        step();
        check("arst_rdy0_b", rdy[0], 0);
        set_port(0, 1'b0);
        rst = 1'b1;
        last_m = 1'b1;
        inv_addr_m = '0;
        step();
        set_txn(0, 1'b0, 1'b0, 32'h40, 16'h0, '0);
        set_txn(1, 1'b0, 1'b0, 32'h80, 16'h0, '0);
        run_round(2'b11);

        // Random traffic over a small aliased address pool
        for (int i = 0; i < 8; i++) begin
            pool[i] = 16 + 37 * i;
            set_txn(0, 1'b1, 1'b0, 32'(pool[i] << 4), 16'hFFFF,
                    {$urandom, $urandom, $urandom, $urandom});
            run_round(2'b01);
        end
        for (int r = 0; r < 40; r++) begin
            logic [1:0] req;
            req = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++)
                set_txn(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        ($urandom & 32'hFFFF_0000) | 32'(pool[$urandom_range(0, 7)] << 4)
                            | 32'($urandom_range(0, 15)),
                        16'($urandom), {$urandom, $urandom, $urandom, $urandom});
            run_round(req);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
